// File: rtl/dmem_arbiter_pkg.sv
// Shared MEM-stage definitions: load/store size codes, arbiter FSM encoding,
// and byte-lane write-enable constants.
// Imported by dmem_lane_align and dmem_arbiter.
package dmem_arbiter_pkg;

   // Load/store size codes carried down the pipeline with each MEM access.
   localparam logic [2:0] BHW_W  = 3'b001;
   localparam logic [2:0] BHW_H  = 3'b010;
   localparam logic [2:0] BHW_B  = 3'b100;
   localparam logic [2:0] BHW_WU = 3'b101;
   localparam logic [2:0] BHW_HU = 3'b111;
   localparam logic [2:0] BHW_BU = 3'b110;

   // Arbiter FSM states.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_DU_WAIT = 2'd1;
   localparam logic [1:0] ST_DU_RESP = 2'd2;

   // Byte-lane write enables, lane 0 = bits [7:0]; shifted by the address offset.
   localparam logic [3:0] WE_NONE = 4'b0000;
   localparam logic [3:0] WE_BYTE = 4'b0001;
   localparam logic [3:0] WE_HALF = 4'b0011;
   localparam logic [3:0] WE_WORD = 4'b1111;

endpackage

// File: rtl/dmem_lane_align.sv
// Purpose: store-lane enables/replication, alignment check, load lane extract + extend.
// Latency: purely combinational.  Backpressure: none (no handshake).
// Ports: i_st_* describe the access being issued, i_ld_* the registered load info
//        paired with i_mem_rdata; o_ld_data is the extended load result.
module dmem_lane_align
   import dmem_arbiter_pkg::*;
(
   input  logic [2:0]  i_st_type,
   input  logic [1:0]  i_st_off,
   input  logic [31:0] i_st_wdata,
   output logic [3:0]  o_st_we,
   output logic [31:0] o_st_wdata,
   output logic        o_misaligned,
   input  logic [2:0]  i_ld_type,
   input  logic [1:0]  i_ld_off,
   input  logic [31:0] i_mem_rdata,
   output logic [31:0] o_ld_data
);

   logic [31:0] shifted;

   // Unknown size codes fall through the default and stay flagged misaligned,
   // so the arbiter suppresses them like any other bad access.
   always_comb begin
      o_st_we      = WE_NONE;
      o_st_wdata   = i_st_wdata;
      o_misaligned = 1'b1;
      case (i_st_type)
         BHW_W, BHW_WU: begin
            o_st_we      = WE_WORD;
            o_misaligned = (i_st_off != 2'b00);
         end
         BHW_H, BHW_HU: begin
            o_st_we      = WE_HALF << {i_st_off[1], 1'b0};
            o_st_wdata   = {2{i_st_wdata[15:0]}};
            o_misaligned = i_st_off[0];
         end
         BHW_B, BHW_BU: begin
            o_st_we      = WE_BYTE << i_st_off;
            o_st_wdata   = {4{i_st_wdata[7:0]}};
            o_misaligned = 1'b0;
         end
         default: ;
      endcase
   end

   // Bring the addressed lane down to bit 0, then extend by size/signedness.
   assign shifted = i_mem_rdata >> {i_ld_off, 3'b000};

   always_comb begin
      o_ld_data = shifted;
      case (i_ld_type)
         BHW_B:   o_ld_data = {{24{shifted[7]}}, shifted[7:0]};
         BHW_BU:  o_ld_data = {24'h0, shifted[7:0]};
         BHW_H:   o_ld_data = {{16{shifted[15]}}, shifted[15:0]};
         BHW_HU:  o_ld_data = {16'h0, shifted[15:0]};
         default: o_ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose: share the single-port data memory between CPU MEM stage (priority) and debug unit.
// Latency: CPU load data and DU read data 1 cycle after issue; DU waits at most MAX_WAIT cycles.
// Backpressure: DU holds i_du_req until o_du_ready; CPU held by a one-cycle o_cpu_stall only.
// Ports: i_cpu_* / o_cpu_* MEM-stage port, i_du_* / o_du_* debug port,
//        o_mem_* / i_mem_rdata synchronous single-port memory (read data one cycle after o_mem_en).
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int MAX_WAIT = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [31:0]       i_cpu_addr,
   input  logic [31:0]       i_cpu_wdata,
   input  logic [2:0]        i_cpu_bhw_type,
   output logic [31:0]       o_cpu_rdata,
   output logic              o_cpu_stall,
   output logic              o_cpu_misaligned,
   input  logic              i_du_req,
   input  logic              i_du_we,
   input  logic [31:0]       i_du_addr,
   input  logic [31:0]       i_du_wdata,
   output logic              o_du_ready,
   output logic              o_du_rvalid,
   output logic [31:0]       o_du_rdata,
   output logic              o_mem_en,
   output logic [3:0]        o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   input  logic [31:0]       i_mem_rdata
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ld_pend_q;
   logic [1:0]       ld_off_q;
   logic [2:0]       ld_type_q;
   logic [31:0]      rdata_q;

   logic [3:0]  cpu_lanes;
   logic [31:0] cpu_wdata_rep;
   logic        cpu_misal;
   logic [31:0] ld_data;
   logic        cpu_act, du_act;
   logic        cpu_issue, du_issue, force_stall;
   logic        cpu_load_issue;
   logic        unused_addr_bits;

   dmem_lane_align u_lane_align (
      .i_st_type    (i_cpu_bhw_type),
      .i_st_off     (i_cpu_addr[1:0]),
      .i_st_wdata   (i_cpu_wdata),
      .o_st_we      (cpu_lanes),
      .o_st_wdata   (cpu_wdata_rep),
      .o_misaligned (cpu_misal),
      .i_ld_type    (ld_type_q),
      .i_ld_off     (ld_off_q),
      .i_mem_rdata  (i_mem_rdata),
      .o_ld_data    (ld_data)
   );

   // Requests are masked while reset is held so every output reads 0 during reset.
   // A misaligned CPU access never reaches memory, so it does not compete with the DU.
   assign cpu_act = i_reset && i_cpu_req && !cpu_misal;
   assign du_act  = i_reset && i_du_req;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cpu_issue   = 1'b0;
      du_issue    = 1'b0;
      force_stall = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cpu_act) begin
               cpu_issue = 1'b1;
               if (du_act) begin
                  cnt_d   = CNT_W'(1);
                  state_d = ST_DU_WAIT;
               end
            end else if (du_act) begin
               du_issue = 1'b1;
               state_d  = i_du_we ? ST_IDLE : ST_DU_RESP;
            end
         end
         ST_DU_WAIT: begin
            if (cpu_act && (cnt_q < CNT_W'(MAX_WAIT))) begin
               cpu_issue = 1'b1;
               cnt_d     = cnt_q + 1'b1;
            end else if (du_act) begin
               // Either the CPU is quiet or the DU has waited long enough:
               // take the slot and hold the pipeline if the CPU wanted it.
               du_issue    = 1'b1;
               force_stall = cpu_act;
               cnt_d       = '0;
               state_d     = i_du_we ? ST_IDLE : ST_DU_RESP;
            end else begin
               // DU withdrew its request; nothing left to protect.
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_DU_RESP: begin
            cpu_issue = cpu_act;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cpu_load_issue = cpu_issue && !i_cpu_we;

   always_comb begin
      o_mem_en    = cpu_issue || du_issue;
      o_mem_we    = WE_NONE;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (du_issue) begin
         o_mem_we    = i_du_we ? WE_WORD : WE_NONE;
         o_mem_addr  = i_du_addr[ADDR_W+1:2];
         o_mem_wdata = i_du_wdata;
      end else if (cpu_issue) begin
         o_mem_we    = i_cpu_we ? cpu_lanes : WE_NONE;
         o_mem_addr  = i_cpu_addr[ADDR_W+1:2];
         o_mem_wdata = cpu_wdata_rep;
      end
   end

   assign o_cpu_stall      = force_stall;
   assign o_cpu_misaligned = i_reset && i_cpu_req && cpu_misal;
   assign o_du_ready       = du_issue;
   assign o_du_rvalid      = (state_q == ST_DU_RESP);
   assign o_du_rdata       = o_du_rvalid ? i_mem_rdata : 32'h0;
   // Fresh data straight from memory in the completion cycle, held value afterwards.
   assign o_cpu_rdata      = ld_pend_q ? ld_data : rdata_q;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         ld_pend_q <= 1'b0;
         ld_off_q  <= 2'b00;
         ld_type_q <= 3'b000;
         rdata_q   <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ld_pend_q <= cpu_load_issue;
         if (cpu_load_issue) begin
            ld_off_q  <= i_cpu_addr[1:0];
            ld_type_q <= i_cpu_bhw_type;
         end
         if (ld_pend_q) begin
            rdata_q <= ld_data;
         end
      end
   end

   // Address bits outside the memory window, and the DU byte offset, are don't-care.
   assign unused_addr_bits = ^{i_cpu_addr[31:ADDR_W+2], i_du_addr[31:ADDR_W+2], i_du_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle synchronous memory.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units after it.
module tb_dmem_arbiter;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_cpu_req, i_cpu_we;
   logic [31:0] i_cpu_addr, i_cpu_wdata;
   logic [2:0]  i_cpu_bhw_type;
   logic [31:0] o_cpu_rdata;
   logic        o_cpu_stall, o_cpu_misaligned;
   logic        i_du_req, i_du_we;
   logic [31:0] i_du_addr, i_du_wdata;
   logic        o_du_ready, o_du_rvalid;
   logic [31:0] o_du_rdata;
   logic        o_mem_en;
   logic [3:0]  o_mem_we;
   logic [9:0]  o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [31:0] i_mem_rdata = 32'h0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem [0:1023];

   dmem_arbiter #(.ADDR_W(10), .MAX_WAIT(8)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
      .i_cpu_wdata(i_cpu_wdata), .i_cpu_bhw_type(i_cpu_bhw_type),
      .o_cpu_rdata(o_cpu_rdata), .o_cpu_stall(o_cpu_stall), .o_cpu_misaligned(o_cpu_misaligned),
      .i_du_req(i_du_req), .i_du_we(i_du_we), .i_du_addr(i_du_addr), .i_du_wdata(i_du_wdata),
      .o_du_ready(o_du_ready), .o_du_rvalid(o_du_rvalid), .o_du_rdata(o_du_rdata),
      .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
   );

   always #5 i_clk = ~i_clk;

   // Read-before-write synchronous memory.
   always @(posedge i_clk) begin
      if (o_mem_en) begin
         i_mem_rdata <= mem[o_mem_addr];
         for (int b = 0; b < 4; b++)
            if (o_mem_we[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      end
   end

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle;
      i_cpu_req = 0; i_cpu_we = 0; i_cpu_addr = 0; i_cpu_wdata = 0; i_cpu_bhw_type = 3'b001;
      i_du_req = 0; i_du_we = 0; i_du_addr = 0; i_du_wdata = 0;
   endtask

   task automatic cpu(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] t);
      i_cpu_req = 1; i_cpu_we = we; i_cpu_addr = addr; i_cpu_wdata = wd; i_cpu_bhw_type = t;
   endtask

   task automatic test_reset;
      i_reset = 0;
      idle();
      repeat (2) @(posedge i_clk);
      #3;
      n_checks++; if (o_mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b want 0", o_mem_en); end
      n_checks++; if (o_mem_we !== 4'b0000) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0000", o_mem_we); end
      n_checks++; if (o_du_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_du_rvalid: got %b want 0", o_du_rvalid); end
      n_checks++; if (o_du_ready !== 1'b0) begin n_fail++; $display("FAIL rst_du_ready: got %b want 0", o_du_ready); end
      n_checks++; if (o_cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_cpu_rdata: got %h want 0", o_cpu_rdata); end
      n_checks++; if (o_cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", o_cpu_stall); end
      n_checks++; if (o_du_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_du_rdata: got %h want 0", o_du_rdata); end
      tick();
      i_reset = 1;
      tick();
   endtask

   task automatic test_store_byte;
      cpu(1, 32'h13, 32'h000000A5, 3'b100);
      #2;
      n_checks++; if (o_mem_en !== 1'b1) begin n_fail++; $display("FAIL sb_en: got %b want 1", o_mem_en); end
      n_checks++; if (o_mem_addr !== 10'd4) begin n_fail++; $display("FAIL sb_addr: got %0d want 4", o_mem_addr); end
      n_checks++; if (o_mem_we !== 4'b1000) begin n_fail++; $display("FAIL sb_we: got %b want 1000", o_mem_we); end
      n_checks++; if (o_mem_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want A5A5A5A5", o_mem_wdata); end
      n_checks++; if (o_cpu_stall !== 1'b0) begin n_fail++; $display("FAIL sb_stall: got %b want 0", o_cpu_stall); end
      tick();
      idle();
   endtask

   task automatic test_load_byte;
      cpu(0, 32'h13, 32'h0, 3'b100);
      #2;
      n_checks++; if (o_mem_we !== 4'b0000) begin n_fail++; $display("FAIL lb_we: got %b want 0000", o_mem_we); end
      tick();
      cpu(0, 32'h13, 32'h0, 3'b110);
      #2;
      n_checks++; if (o_cpu_rdata !== 32'hFFFFFFA5) begin n_fail++; $display("FAIL lb_data: got %h want FFFFFFA5", o_cpu_rdata); end
      tick();
      idle();
      #2;
      n_checks++; if (o_cpu_rdata !== 32'h000000A5) begin n_fail++; $display("FAIL lbu_data: got %h want 000000A5", o_cpu_rdata); end
      tick();
      #2;
      n_checks++; if (o_cpu_rdata !== 32'h000000A5) begin n_fail++; $display("FAIL rdata_hold: got %h want 000000A5", o_cpu_rdata); end
      tick();
   endtask

   task automatic test_halfword;
      cpu(1, 32'h06, 32'h0000BEEF, 3'b010);
      #2;
      n_checks++; if (o_mem_we !== 4'b1100) begin n_fail++; $display("FAIL sh_we: got %b want 1100", o_mem_we); end
      n_checks++; if (o_mem_wdata !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL sh_wdata: got %h want BEEFBEEF", o_mem_wdata); end
      tick();
      cpu(0, 32'h05, 32'h0, 3'b010);
      #2;
      n_checks++; if (o_cpu_misaligned !== 1'b1) begin n_fail++; $display("FAIL lh_mis: got %b want 1", o_cpu_misaligned); end
      n_checks++; if (o_mem_en !== 1'b0) begin n_fail++; $display("FAIL lh_mis_en: got %b want 0", o_mem_en); end
      n_checks++; if (o_cpu_stall !== 1'b0) begin n_fail++; $display("FAIL lh_mis_stall: got %b want 0", o_cpu_stall); end
      tick();
      cpu(1, 32'h05, 32'hFFFFFFFF, 3'b001);
      #2;
      n_checks++; if (o_mem_en !== 1'b0) begin n_fail++; $display("FAIL sw_mis_en: got %b want 0", o_mem_en); end
      tick();
      cpu(0, 32'h04, 32'h0, 3'b011);
      #2;
      n_checks++; if (o_cpu_misaligned !== 1'b1) begin n_fail++; $display("FAIL bad_type: got %b want 1", o_cpu_misaligned); end
      tick();
      cpu(0, 32'h04, 32'h0, 3'b001);
      tick();
      cpu(0, 32'h06, 32'h0, 3'b111);
      #2;
      n_checks++; if (o_cpu_rdata !== 32'hBEEF0001) begin n_fail++; $display("FAIL lw_word1: got %h want BEEF0001", o_cpu_rdata); end
      tick();
      cpu(0, 32'h06, 32'h0, 3'b010);
      #2;
      n_checks++; if (o_cpu_rdata !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu: got %h want 0000BEEF", o_cpu_rdata); end
      tick();
      idle();
      #2;
      n_checks++; if (o_cpu_rdata !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL lh: got %h want FFFFBEEF", o_cpu_rdata); end
      tick();
   endtask

   task automatic test_du_read;
      i_du_req = 1; i_du_we = 0; i_du_addr = 32'h10;
      #2;
      n_checks++; if (o_du_ready !== 1'b1) begin n_fail++; $display("FAIL du_rd_ready: got %b want 1", o_du_ready); end
      n_checks++; if (o_mem_addr !== 10'd4) begin n_fail++; $display("FAIL du_rd_addr: got %0d want 4", o_mem_addr); end
      n_checks++; if (o_mem_we !== 4'b0000) begin n_fail++; $display("FAIL du_rd_we: got %b want 0000", o_mem_we); end
      tick();
      i_du_req = 0;
      #2;
      n_checks++; if (o_du_rvalid !== 1'b1) begin n_fail++; $display("FAIL du_rvalid: got %b want 1", o_du_rvalid); end
      n_checks++; if (o_du_rdata !== 32'hA5DE0004) begin n_fail++; $display("FAIL du_rdata: got %h want A5DE0004", o_du_rdata); end
      tick();
      #2;
      n_checks++; if (o_du_rvalid !== 1'b0) begin n_fail++; $display("FAIL du_rvalid_pulse: got %b want 0", o_du_rvalid); end
      tick();
   endtask

   task automatic test_du_wait;
      int   ready_idx  = -1;
      int   stall_cnt  = 0;
      bit   done       = 0;
      logic [3:0] we_at = 4'b0;
      logic [9:0] addr_at = 10'd0;
      logic after_en = 1'b0, after_stall = 1'b1;
      i_du_req = 1; i_du_we = 1; i_du_addr = 32'h20; i_du_wdata = 32'h12345678;
      cpu(0, 32'h0, 32'h0, 3'b001);
      for (int i = 0; i < 20 && !done; i++) begin
         #2;
         if (o_cpu_stall) stall_cnt++;
         if (ready_idx >= 0) begin
            after_en = o_mem_en; after_stall = o_cpu_stall; done = 1;
         end else if (o_du_ready) begin
            ready_idx = i; we_at = o_mem_we; addr_at = o_mem_addr;
         end
         tick();
         if (ready_idx >= 0) i_du_req = 0;
      end
      idle();
      #2;
      n_checks++; if (ready_idx != 8) begin n_fail++; $display("FAIL wait_ready_cycle: got %0d want 8", ready_idx); end
      n_checks++; if (stall_cnt != 1) begin n_fail++; $display("FAIL wait_stall_cycles: got %0d want 1", stall_cnt); end
      n_checks++; if (we_at !== 4'b1111) begin n_fail++; $display("FAIL wait_du_we: got %b want 1111", we_at); end
      n_checks++; if (addr_at !== 10'd8) begin n_fail++; $display("FAIL wait_du_addr: got %0d want 8", addr_at); end
      n_checks++; if (after_en !== 1'b1 || after_stall !== 1'b0) begin n_fail++; $display("FAIL wait_cpu_after: en %b stall %b want 1 0", after_en, after_stall); end
      n_checks++; if (o_cpu_rdata !== 32'hC0DE0000) begin n_fail++; $display("FAIL wait_cpu_rdata: got %h want C0DE0000", o_cpu_rdata); end
      tick();
   endtask

   task automatic test_simultaneous;
      cpu(0, 32'h04, 32'h0, 3'b001);
      i_du_req = 1; i_du_we = 0; i_du_addr = 32'h20;
      #2;
      n_checks++; if (o_du_ready !== 1'b0 || o_mem_addr !== 10'd1) begin n_fail++; $display("FAIL sim_cpu_first: ready %b addr %0d want 0 1", o_du_ready, o_mem_addr); end
      tick();
      i_cpu_req = 0;
      #2;
      n_checks++; if (o_du_ready !== 1'b1 || o_mem_addr !== 10'd8) begin n_fail++; $display("FAIL sim_du_next: ready %b addr %0d want 1 8", o_du_ready, o_mem_addr); end
      n_checks++; if (o_cpu_stall !== 1'b0) begin n_fail++; $display("FAIL sim_stall: got %b want 0", o_cpu_stall); end
      n_checks++; if (o_cpu_rdata !== 32'hBEEF0001) begin n_fail++; $display("FAIL sim_cpu_rdata: got %h want BEEF0001", o_cpu_rdata); end
      tick();
      i_du_req = 0;
      #2;
      n_checks++; if (o_du_rvalid !== 1'b1 || o_du_rdata !== 32'h12345678) begin n_fail++; $display("FAIL sim_du_rdata: rvalid %b data %h want 1 12345678", o_du_rvalid, o_du_rdata); end
      tick();
      idle();
   endtask

   task automatic test_reset_in_resp;
      i_du_req = 1; i_du_we = 0; i_du_addr = 32'h10;
      tick();
      i_du_req = 0;
      #2;
      n_checks++; if (o_du_rvalid !== 1'b1) begin n_fail++; $display("FAIL rr_pre_rvalid: got %b want 1", o_du_rvalid); end
      i_reset = 0;
      #1;
      n_checks++; if (o_du_rvalid !== 1'b0) begin n_fail++; $display("FAIL rr_rvalid: got %b want 0", o_du_rvalid); end
      n_checks++; if (o_cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rr_cpu_rdata: got %h want 0", o_cpu_rdata); end
      tick();
      #2;
      n_checks++; if (o_du_rvalid !== 1'b0) begin n_fail++; $display("FAIL rr_rvalid_hold: got %b want 0", o_du_rvalid); end
      i_reset = 1;
      tick();
      i_du_req = 1; i_du_we = 0; i_du_addr = 32'h10;
      #2;
      n_checks++; if (o_du_ready !== 1'b1) begin n_fail++; $display("FAIL rr_post_ready: got %b want 1", o_du_ready); end
      tick();
      i_du_req = 0;
      cpu(0, 32'h10, 32'h0, 3'b001);
      #2;
      n_checks++; if (o_du_rvalid !== 1'b1 || o_du_rdata !== 32'hA5DE0004) begin n_fail++; $display("FAIL rr_post_rdata: rvalid %b data %h want 1 A5DE0004", o_du_rvalid, o_du_rdata); end
      tick();
      idle();
      #2;
      n_checks++; if (o_cpu_rdata !== 32'hA5DE0004) begin n_fail++; $display("FAIL rr_post_cpu: got %h want A5DE0004", o_cpu_rdata); end
      tick();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
      test_reset();
      test_store_byte();
      test_load_byte();
      test_halfword();
      test_du_read();
      test_du_wait();
      test_simultaneous();
      test_reset_in_resp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
